// File: rtl/uart_pkg.sv
// Shared UART encodings, oversampling constants and rx FSM state codes (also used by the TX core).
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    localparam logic [3:0] TICK_DECIDE      = 4'd9;   // majority of ticks 7,8,9
    localparam logic [3:0] TICK_HALF_DECIDE = 4'd7;   // half stop bit: majority of ticks 5,6,7
    localparam logic [3:0] TICK_LAST        = 4'd15;

    // stop_type 2 and 3 both mean two stop bits
    localparam logic [1:0] STOP_1   = 2'd0;
    localparam logic [1:0] STOP_1P5 = 2'd1;

    localparam logic [1:0] CHECK_EVEN  = 2'd0;
    localparam logic [1:0] CHECK_ODD   = 2'd1;
    localparam logic [1:0] CHECK_MARK  = 2'd2;
    localparam logic [1:0] CHECK_SPACE = 2'd3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Receiver-side bundle: line, enable and frame configuration in; byte, status and pulses out.
interface uart_rx_sampler_if #(
    parameter int unsigned BAUD_DIV_WIDTH = 8
);
    logic                      en;
    logic [BAUD_DIV_WIDTH-1:0] baud_div;
    logic [1:0]                data_type;
    logic [1:0]                stop_type;
    logic                      check_en;
    logic [1:0]                check_type;
    logic                      rx;
    logic [7:0]                data;
    logic                      busy;
    logic                      ack;
    logic                      err;
    logic                      brk;

    modport master (
        output en, baud_div, data_type, stop_type, check_en, check_type, rx,
        input  data, busy, ack, err, brk
    );

    modport slave (
        input  en, baud_div, data_type, stop_type, check_en, check_type, rx,
        output data, busy, ack, err, brk
    );
endinterface

// File: rtl/uart_baud_tick.sv
// 16x oversample tick generator: counts 0..div, ticks on div, synchronous clear realigns phase.
module uart_baud_tick #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] div,
    output logic             tick
);
    logic [WIDTH-1:0] cnt;

    assign tick = (cnt == div);

    always_ff @(posedge clk) begin
        if (rst || clr || tick) cnt <= '0;
        else                    cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver front end: sync, start detect, 3-tick majority, 5-8 data bits, parity, stop.
// Define UART_RX_BREAK_DETECT_EN to report all-zero frames as brk instead of ack+err.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV_WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    uart_rx_sampler_if.slave  bus
);
    logic rx_m, rx_s, rx_prev;
    logic [2:0] state;
    logic [BAUD_DIV_WIDTH-1:0] div_l;
    logic [1:0] dtype_l, stype_l, ctype_l;
    logic       cen_l;
    logic [3:0] os_cnt;
    logic [2:0] bit_cnt;
    logic       stop_cnt;
    logic [1:0] hist;
    logic [7:0] shreg, data_q;
    logic       par_err, stop_err;
    logic       ack_q, err_q, brk_q;
    logic       tick, start_det, half_bit, decide, bit_end, bit_val;
    logic       last_data, last_stop, exp_par;
`ifdef UART_RX_BREAK_DETECT_EN
    logic       all_zero;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            {rx_m, rx_s, rx_prev} <= '1;
        end else begin
            rx_m    <= bus.rx;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
        end
    end

    // rx_prev must be seen high first, so a line already low when en rises is not a start
    assign start_det = (state == ST_IDLE) && bus.en && rx_prev && !rx_s;

    uart_baud_tick #(.WIDTH(BAUD_DIV_WIDTH)) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_det),
        .div  (div_l),
        .tick (tick)
    );

    assign half_bit  = (state == ST_STOP) && stop_cnt && (stype_l == STOP_1P5);
    assign decide    = tick && (os_cnt == (half_bit ? TICK_HALF_DECIDE : TICK_DECIDE));
    assign bit_end   = tick && (os_cnt == TICK_LAST);
    assign bit_val   = majority3(hist[1], hist[0], rx_s);
    assign last_data = (bit_cnt == ({1'b0, dtype_l} + 3'd4));
    assign last_stop = stop_cnt || (stype_l == STOP_1);

    always_comb begin
        exp_par = 1'b0;
        case (ctype_l)
            CHECK_EVEN:  exp_par = ^shreg;
            CHECK_ODD:   exp_par = ~^shreg;
            CHECK_MARK:  exp_par = 1'b1;
            CHECK_SPACE: exp_par = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            div_l    <= '0;
            dtype_l  <= '0;
            stype_l  <= '0;
            ctype_l  <= '0;
            cen_l    <= 1'b0;
            os_cnt   <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            hist     <= '0;
            shreg    <= '0;
            data_q   <= '0;
            par_err  <= 1'b0;
            stop_err <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            brk_q    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            all_zero <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            brk_q <= 1'b0;
            if (tick) begin
                os_cnt <= os_cnt + 1'b1;
                hist   <= {hist[0], rx_s};
            end
`ifdef UART_RX_BREAK_DETECT_EN
            if (decide) all_zero <= all_zero & ~bit_val;
`endif
            if (!bus.en) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: if (start_det) begin
                        div_l    <= bus.baud_div;
                        dtype_l  <= bus.data_type;
                        stype_l  <= bus.stop_type;
                        ctype_l  <= bus.check_type;
                        cen_l    <= bus.check_en;
                        os_cnt   <= '0;
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        shreg    <= '0;
                        par_err  <= 1'b0;
                        stop_err <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                        all_zero <= 1'b1;
`endif
                        state    <= ST_START;
                    end
                    ST_START: begin
                        if (decide && bit_val) state <= ST_IDLE;
                        else if (bit_end)      state <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (decide) shreg[bit_cnt] <= bit_val;
                        if (bit_end) begin
                            if (last_data) begin
                                bit_cnt <= '0;
                                state   <= cen_l ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (decide)  par_err <= (bit_val != exp_par);
                        if (bit_end) state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        // frame ends at the last stop mid-sample so the next start edge is not missed
                        if (decide) begin
                            if (!bit_val) stop_err <= 1'b1;
                            if (last_stop) begin
                                state <= ST_IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
                                if (all_zero && !bit_val) begin
                                    brk_q <= 1'b1;
                                    state <= ST_BREAK;
                                end else
`endif
                                begin
                                    ack_q  <= 1'b1;
                                    err_q  <= par_err | stop_err | ~bit_val;
                                    data_q <= shreg;
                                end
                            end
                        end else if (bit_end) begin
                            stop_cnt <= 1'b1;
                        end
                    end
                    ST_BREAK: begin
`ifdef UART_RX_BREAK_DETECT_EN
                        if (rx_s) state <= ST_IDLE;
`else
                        state <= ST_IDLE;
`endif
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.data = data_q;
    assign bus.busy = (state != ST_IDLE);
    assign bus.ack  = ack_q & bus.en & ~rst;
    assign bus.err  = err_q & bus.en & ~rst;
    assign bus.brk  = brk_q & bus.en & ~rst;
endmodule
